// File: rtl/mem_io_bridge_if.sv
// Bus bundle between the CPU-side environment (master) and the load/store
// bridge (slave): CPU request/result, data-memory port and I/O channel port.
interface mem_io_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int IO_CH  = 4,
    parameter int IO_W   = 8
);
    logic                   req;
    logic                   we;
    logic                   neg;
    logic [ADDR_W-1:0]      addr_in;
    logic [DATA_W-1:0]      r_rdata;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic [DATA_W-1:0]      r_wdata;
    logic [ADDR_W-1:0]      addr_out;
    logic                   m_wen;
    logic [DATA_W-1:0]      m_wdata;
    logic [DATA_W-1:0]      m_rdata;
    logic [IO_CH-1:0]       io_rd_en;
    logic [IO_CH-1:0]       io_wr_en;
    logic [IO_W-1:0]        io_wdata;
    logic [IO_CH*IO_W-1:0]  io_rdata;

    modport master (
        output req, we, neg, addr_in, r_rdata, m_rdata, io_rdata,
        input  busy, done, err, r_wdata, addr_out, m_wen, m_wdata,
               io_rd_en, io_wr_en, io_wdata
    );

    modport slave (
        input  req, we, neg, addr_in, r_rdata, m_rdata, io_rdata,
        output busy, done, err, r_wdata, addr_out, m_wen, m_wdata,
               io_rd_en, io_wr_en, io_wdata
    );
endinterface

// File: rtl/mem_io_bridge.sv
// Load/store router: decodes each CPU access to data memory, one of IO_CH
// byte-wide I/O channels, or an unmapped-I/O error, and handshakes req/done.
module mem_io_bridge #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                IO_CH       = 4,
    parameter int                IO_W        = 8,
    parameter logic [ADDR_W-1:0] IO_BASE     = 32'hFFFF_FC00,
    parameter int                IO_STRIDE   = 16,
    parameter int                WAIT_CYCLES = 2
) (
    input  logic            clock,
    input  logic            reset,
    mem_io_bridge_if.slave  bus
);
    localparam int CH_W  = (IO_CH > 1) ? $clog2(IO_CH) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int SHIFT = $clog2(IO_STRIDE);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, MEM_ACC, MEM_RD, IO_WAIT, DONE} state_t;

    state_t            state;
    logic              we_q;
    logic              neg_q;
    logic [CH_W-1:0]   ch_q;
    logic [CNT_W-1:0]  cnt;

    logic [ADDR_W-1:0] io_off;
    logic [ADDR_W-1:0] ch_idx;
    logic              is_mem;
    logic              is_err;
    logic [IO_CH-1:0]  sel;
    logic [IO_W-1:0]   lane;

    // Channel decode is done on the live address; only its result is latched.
    assign io_off = bus.addr_in - IO_BASE;
    assign ch_idx = io_off >> SHIFT;
    assign is_mem = (bus.addr_in < IO_BASE);
    assign is_err = (ch_idx >= ADDR_W'(IO_CH));
    assign sel    = IO_CH'(1) << ch_idx[CH_W-1:0];
    assign lane   = bus.io_rdata[int'(ch_q)*IO_W +: IO_W];

    // Zero-extend a channel byte, optionally returning its two's-complement negation.
    function automatic logic [DATA_W-1:0] io_extend(input logic [IO_W-1:0] v, input logic n);
        logic [DATA_W-1:0] z;
        z = DATA_W'(v);
        return n ? (DATA_W'(0) - z) : z;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            neg_q        <= 1'b0;
            ch_q         <= '0;
            cnt          <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
            bus.r_wdata  <= '0;
            bus.addr_out <= '0;
            bus.m_wen    <= 1'b0;
            bus.m_wdata  <= '0;
            bus.io_rd_en <= '0;
            bus.io_wr_en <= '0;
            bus.io_wdata <= '0;
        end else begin
            bus.done  <= 1'b0;
            bus.err   <= 1'b0;
            bus.m_wen <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        we_q     <= bus.we;
                        neg_q    <= bus.neg;
                        ch_q     <= ch_idx[CH_W-1:0];
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        if (is_mem) begin
                            state        <= MEM_ACC;
                            bus.addr_out <= bus.addr_in;
                            if (bus.we) begin
                                bus.m_wen   <= 1'b1;
                                bus.m_wdata <= bus.r_rdata;
                            end
                        end else if (is_err) begin
                            state       <= DONE;
                            bus.done    <= 1'b1;
                            bus.err     <= 1'b1;
                            bus.r_wdata <= '0;
                        end else begin
                            state <= IO_WAIT;
                            if (bus.we) begin
                                bus.io_wr_en <= sel;
                                bus.io_wdata <= bus.r_rdata[IO_W-1:0];
                            end else begin
                                bus.io_rd_en <= sel;
                            end
                        end
                    end
                end
                MEM_ACC: begin
                    state    <= we_q ? DONE : MEM_RD;
                    bus.done <= we_q;
                end
                MEM_RD: begin
                    state       <= DONE;
                    bus.done    <= 1'b1;
                    bus.r_wdata <= bus.m_rdata;
                end
                IO_WAIT: begin
                    // Store strobe lasts only the first wait cycle; read strobe spans all of them.
                    bus.io_wr_en <= '0;
                    if (cnt == LAST_WAIT) begin
                        state        <= DONE;
                        bus.done     <= 1'b1;
                        bus.io_rd_en <= '0;
                        if (!we_q) bus.r_wdata <= io_extend(lane, neg_q);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_io_bridge.sv
// Scoreboard bench for mem_io_bridge: a driver issues directed and random
// accesses and queues expected responses; a monitor checks each done pulse.
module tb_mem_io_bridge;
    localparam int ADDR_W = 32, DATA_W = 32, IO_CH = 4, IO_W = 8;
    localparam int IO_STRIDE = 16, WAIT_CYCLES = 2;
    localparam logic [31:0] IO_BASE = 32'hFFFF_FC00;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mem_io_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IO_CH(IO_CH), .IO_W(IO_W)) bus();

    mem_io_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IO_CH(IO_CH), .IO_W(IO_W),
        .IO_BASE(IO_BASE), .IO_STRIDE(IO_STRIDE), .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Data-memory block RAM with one-cycle read latency.
    logic [31:0] ram [64];
    always @(posedge clock) begin
        if (bus.m_wen) ram[bus.addr_out[7:2]] <= bus.m_wdata;
        bus.m_rdata <= ram[bus.addr_out[7:2]];
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          rd_cnt;
        logic [3:0]  rd_mask;
        int          wr_cnt;
        logic [3:0]  wr_mask;
        logic [7:0]  io_wd;
        int          mw_cnt;
        logic [31:0] m_wd;
        logic [31:0] m_addr;
        int          acc;
    } exp_t;

    exp_t q[$];

    // Reference state: memory contents and the last load result.
    logic [31:0] ref_mem [64];
    logic [31:0] last_rdata = 32'd0;

    // Monitor: accumulate strobe activity, check everything at each done.
    initial begin
        int rd_cnt, wr_cnt, mw_cnt, multi, nstb;
        logic [3:0] rd_mask, wr_mask;
        logic [7:0] io_wd;
        logic [31:0] m_wd, m_ad;
        exp_t e;
        rd_cnt = 0; wr_cnt = 0; mw_cnt = 0; multi = 0;
        rd_mask = 0; wr_mask = 0; io_wd = 0; m_wd = 0; m_ad = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                rd_cnt = 0; wr_cnt = 0; mw_cnt = 0; multi = 0; rd_mask = 0; wr_mask = 0;
            end else begin
                nstb = $countones({bus.io_rd_en, bus.io_wr_en, bus.m_wen});
                if (nstb > 1 || (bus.done && nstb != 0)) multi++;
                if (bus.io_rd_en != 0) begin rd_cnt++; rd_mask |= bus.io_rd_en; end
                if (bus.io_wr_en != 0) begin wr_cnt++; wr_mask |= bus.io_wr_en; io_wd = bus.io_wdata; end
                if (bus.m_wen) begin mw_cnt++; m_wd = bus.m_wdata; m_ad = bus.addr_out; end
                if (bus.done) begin
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done: got done=1 required no pending access (t=%0t)", $time);
                    end else begin
                        e = q.pop_front();
                        check("err", bus.err, e.err);
                        check("r_wdata", bus.r_wdata, e.rdata);
                        check("latency", cyc - e.acc, e.lat - 1);
                        check("busy_in_done", bus.busy, 1);
                        check("rd_cycles", rd_cnt, e.rd_cnt);
                        check("rd_mask", rd_mask, e.rd_mask);
                        check("wr_cycles", wr_cnt, e.wr_cnt);
                        check("wr_mask", wr_mask, e.wr_mask);
                        check("mwen_cycles", mw_cnt, e.mw_cnt);
                        check("strobe_overlap", multi, 0);
                        if (e.wr_cnt == 1) check("io_wdata", io_wd, e.io_wd);
                        if (e.mw_cnt == 1) begin
                            check("m_wdata", m_wd, e.m_wd);
                            check("addr_out", m_ad, e.m_addr);
                        end
                    end
                    rd_cnt = 0; wr_cnt = 0; mw_cnt = 0; multi = 0; rd_mask = 0; wr_mask = 0;
                end
            end
        end
    end

    task automatic wait_idle();
        int guard = 0;
        while (bus.busy !== 1'b0 && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (bus.busy !== 1'b0) begin
            checks++; errors++;
            $display("FAIL idle_timeout: got busy=%b required 0 within 50 cycles", bus.busy);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic w, input logic n,
                                   input logic [31:0] d, input logic [31:0] lanes);
        exp_t e = '{default: 0};
        logic [31:0] ch, v;
        if (a < IO_BASE) begin
            if (w) begin
                e.lat = 2; e.mw_cnt = 1; e.m_wd = d; e.m_addr = a;
                ref_mem[a[7:2]] = d;
                e.rdata = last_rdata;
            end else begin
                e.lat = 3;
                e.rdata = ref_mem[a[7:2]];
                last_rdata = e.rdata;
            end
        end else begin
            ch = (a - IO_BASE) / IO_STRIDE;
            if (ch >= IO_CH) begin
                e.err = 1; e.lat = 1; e.rdata = 0;
                last_rdata = 0;
            end else begin
                e.lat = 1 + WAIT_CYCLES;
                if (w) begin
                    e.wr_cnt = 1; e.wr_mask = 4'(1 << ch); e.io_wd = d[7:0];
                    e.rdata = last_rdata;
                end else begin
                    e.rd_cnt = WAIT_CYCLES; e.rd_mask = 4'(1 << ch);
                    v = {24'd0, lanes[ch*8 +: 8]};
                    e.rdata = n ? (32'd0 - v) : v;
                    last_rdata = e.rdata;
                end
            end
        end
        return e;
    endfunction

    task automatic issue(input logic [31:0] a, input logic w, input logic n,
                         input logic [31:0] d, input logic [31:0] lanes, input bit hold);
        exp_t e;
        wait_idle();
        e = model(a, w, n, d, lanes);
        bus.req = 1'b1; bus.we = w; bus.neg = n; bus.addr_in = a;
        bus.r_rdata = d; bus.io_rdata = lanes;
        @(posedge clock);
        #1;
        e.acc = cyc;
        q.push_back(e);
        if (hold) begin
            // Keep requesting while busy; these must all be dropped.
            for (int k = 0; k < 50; k++) begin
                @(negedge clock);
                if (bus.done) break;
                bus.addr_in = $urandom;
                bus.we = 1'($urandom);
                bus.r_rdata = $urandom;
            end
        end
        bus.req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation time %0t required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, lanes;
        int kind;
        for (int i = 0; i < 64; i++) begin ram[i] = 32'd0; ref_mem[i] = 32'd0; end
        bus.req = 0; bus.we = 0; bus.neg = 0; bus.addr_in = 0; bus.r_rdata = 0; bus.io_rdata = 0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_r_wdata", bus.r_wdata, 0);
        check("rst_addr_out", bus.addr_out, 0);
        check("rst_m_wen", bus.m_wen, 0);
        check("rst_m_wdata", bus.m_wdata, 0);
        check("rst_io_rd_en", bus.io_rd_en, 0);
        check("rst_io_wr_en", bus.io_wr_en, 0);
        check("rst_io_wdata", bus.io_wdata, 0);
        reset = 1'b1;

        issue(32'h0000_0040, 1, 0, 32'hDEAD_BEEF, 32'h0, 0);
        issue(32'h0000_0040, 0, 0, 32'h0, 32'h0, 0);
        issue(32'hFFFF_FC20, 0, 0, 32'h0, 32'h0005_0000, 0);
        issue(32'hFFFF_FC20, 0, 1, 32'h0, 32'h0005_0000, 0);
        issue(32'hFFFF_FC20, 0, 1, 32'h0, 32'hFF00_FFFF, 0);
        issue(32'hFFFF_FC20, 0, 0, 32'h0, 32'h0005_0000, 0);
        issue(32'hFFFF_FC10, 1, 0, 32'h1234_56A5, 32'h0, 0);
        issue(32'hFFFF_FC40, 0, 0, 32'h0, 32'hFFFF_FFFF, 0);
        issue(32'hFFFF_FC2C, 0, 1, 32'h0, 32'h0080_0000, 1);
        issue(32'hFFFF_FC3F, 0, 0, 32'h0, 32'h7F00_0000, 1);

        // Reset during the first I/O wait cycle aborts the load.
        wait_idle();
        bus.req = 1; bus.we = 0; bus.neg = 0; bus.addr_in = 32'hFFFF_FC20; bus.io_rdata = 32'h0033_0000;
        @(posedge clock);
        #1 bus.req = 0;
        @(negedge clock);
        check("pre_rst_io_rd_en", bus.io_rd_en, 4'b0100);
        #2 reset = 1'b0;
        #1;
        check("abort_io_rd_en", bus.io_rd_en, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_r_wdata", bus.r_wdata, 0);
        last_rdata = 32'd0;
        repeat (3) @(negedge clock);
        #1 reset = 1'b1;
        repeat (4) @(negedge clock);
        issue(32'h0000_0040, 0, 0, 32'h0, 32'h0, 0);

        for (int t = 0; t < 150; t++) begin
            kind = $urandom_range(0, 9);
            lanes = $urandom;
            if (kind < 4)      a = {24'd0, 6'($urandom), 2'b00};
            else if (kind < 8) a = IO_BASE + 32'($urandom_range(0, IO_CH * IO_STRIDE - 1));
            else               a = IO_BASE + 32'($urandom_range(IO_CH * IO_STRIDE, 1023));
            issue(a, 1'($urandom), 1'($urandom), $urandom, lanes, ($urandom_range(0, 3) == 0));
        end

        wait_idle();
        repeat (3) @(negedge clock);
        check("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_io_bridge.md
# mem_io_bridge

Parametrised, clocked load/store router between the CPU datapath and either data memory or up to `IO_CH` byte-wide I/O channels. It replaces the single-cycle, two-port combinational memory/IO selector with a request/done handshake, address-decoded channel selection, and configurable I/O wait states. It adds correct two's-complement negation of I/O input and an error response for unmapped I/O addresses. It sits between the ALU/register file (address, store data, load result) and the data-memory block RAM and I/O peripherals.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data word width
- `IO_CH`, 4, number of I/O channels (1..16)
- `IO_W`, 8, I/O channel data width (must be ≤ `DATA_W`)
- `IO_BASE`, 32'hFFFF_FC00, first I/O address
- `IO_STRIDE`, 16, address bytes per channel (power of two)
- `WAIT_CYCLES`, 2, I/O access wait states (≥ 1)
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req`  in  1  access request, sampled only when `busy` = 0
- `we`  in  1  1 = store, 0 = load (sampled with `req`)
- `neg`  in  1  I/O load returns the negated value (sampled with `req`)
- `addr_in`  in  `ADDR_W`  byte address from ALU
- `r_rdata`  in  `DATA_W`  store data from register file
- `busy`  out  1  access in progress
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  one-cycle pulse with `done` for unmapped I/O
- `r_wdata`  out  `DATA_W`  load result to register file
- `addr_out`  out  `ADDR_W`  address to data memory
- `m_wen`  out  1  data-memory write enable
- `m_wdata`  out  `DATA_W`  data-memory write data
- `m_rdata`  in  `DATA_W`  data-memory read data, valid one cycle after the address
- `io_rd_en`  out  `IO_CH`  per-channel read strobe
- `io_wr_en`  out  `IO_CH`  per-channel write strobe
- `io_wdata`  out  `IO_W`  I/O write data
- `io_rdata`  in  `IO_CH*IO_W`  channel k is `io_rdata[k*IO_W +: IO_W]`

## Operation
- Decode at accept:
  - `addr_in < IO_BASE` selects memory.
  - Otherwise the access targets channel `ch = (addr_in - IO_BASE) / IO_STRIDE`.
  - If `ch ≥ IO_CH`, the access is an error.
- FSM states: `IDLE`, `MEM_ACC`, `MEM_RD`, `IO_WAIT`, `DONE`.
- `IDLE`: when `req` = 1, latch `addr_in`, `we`, `neg`, `r_rdata`, and `ch`.
  - Memory access goes to `MEM_ACC`.
  - Valid I/O access goes to `IO_WAIT`.
  - Error access goes to `DONE`, with `err` = 1 and `r_wdata` = 0.
- `MEM_ACC`: `addr_out` = latched address.
  - Store: `m_wen` = 1 and `m_wdata` = latched store data, for this cycle only; next state is `DONE`.
  - Load: next state is `MEM_RD`.
- `MEM_RD`: capture `m_rdata` into `r_wdata`; next state is `DONE`.
- `IO_WAIT`: a wait counter runs `WAIT_CYCLES` cycles.
  - Load: `io_rd_en[ch]` is held high for all wait cycles.
  - Store: `io_wr_en[ch]` = 1 on the first wait cycle only; `io_wdata` = `r_rdata[IO_W-1:0]`.
  - On the last wait cycle of a load, capture channel `ch` into `r_wdata` and go to `DONE`:
    - `neg` = 0: zero-extend the channel value.
    - `neg` = 1: `0 - zero_extend(value)`, mod 2^`DATA_W`. An input of 0 yields 0.
- `DONE`: `done` = 1 for one cycle, then `IDLE`.
- `busy` = 1 in every state except `IDLE`.
- A store leaves `r_wdata` unchanged. `r_wdata` holds its value between loads.
- At most one strobe bit is active in any cycle. No strobe is active outside `MEM_ACC` or `IO_WAIT`.
- `req` while `busy` = 1 is ignored and is not queued.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State is `IDLE`.
  - All outputs are 0: `busy`, `done`, `err`, `r_wdata`, `addr_out`, `m_wen`, `m_wdata`, `io_rd_en`, `io_wr_en`, `io_wdata`.
- Latency, with accept at edge T:

| Access | States | `done` high in cycle |
|---|---|---|
| Memory store | `MEM_ACC` at T+1 | T+2 |
| Memory load | `MEM_ACC` T+1, `MEM_RD` T+2 | T+3 |
| I/O (load or store) | `IO_WAIT` T+1 .. T+`WAIT_CYCLES` | T+1+`WAIT_CYCLES` |
| Error | none | T+1 |

- `r_wdata` is valid in the `done` cycle and is stable until the next load completes.
- A new `req` can be accepted in the cycle after `done` (back-to-back throughput = latency + 1).
- Reset asserted mid-access (any state) drops all strobes immediately. The aborted access never produces `done`.
- `addr_out`, `m_wdata`, and `io_wdata` are registered and hold their last values outside strobes.

## Test plan
- **Memory store then load:** store to 0x0000_0040 with data 0xDEAD_BEEF, then load from the same address.
  - Store: `m_wen` pulses at T+1 with `m_wdata` = 0xDEADBEEF; `done` at T+2.
  - Load: `r_wdata` = 0xDEADBEEF at T+3 with `done`.
- **I/O load, unsigned and negated:** channel 2 at 0xFFFFFC20, `io_rdata` lane 2 = 0x05.
  - `neg` = 0: `io_rd_en` = 4'b0100 for 2 cycles; `r_wdata` = 0x00000005 at T+3.
  - `neg` = 1: `r_wdata` = 0xFFFFFFFB.
  - `neg` = 1 with lane value 0x00: `r_wdata` = 0x00000000.
- **I/O store:** channel 1 at 0xFFFFFC10, `r_rdata` = 0x1234_56A5.
  - `io_wr_en` = 4'b0010 for exactly one cycle; `io_wdata` = 0xA5.
  - `done` at T+3; `r_wdata` unchanged.
- **Unmapped I/O:** load from 0xFFFFFC40 (`ch` = 4).
  - `done` and `err` both high at T+1; `r_wdata` = 0.
  - No strobes asserted.
- **Busy and reset:** `req` held high during an I/O load is ignored.
  - Asserting `reset` in the first `IO_WAIT` cycle clears `io_rd_en`, `busy`, and `r_wdata` in the same cycle; no `done` follows.
  - After release, a new memory load completes normally.
